// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared constants and FSM encoding for the PWM duty scheduler
package pwm_sched_pkg;

  localparam int PWM_NUM_CH         = 4;
  localparam int PWM_DATA_WIDTH     = 12;
  localparam int PWM_PRESCALE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/pwm_sched_channel.sv
// rtl/pwm_sched_channel.sv - one channel: shadow/active duty, pending flag and registered compare
module pwm_sched_channel
  import pwm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = PWM_DATA_WIDTH
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic [DATA_WIDTH-1:0] duty,
  input  logic                  duty_valid,
  output logic                  duty_ready,
  input  logic                  arm,
  input  logic                  wrap,
  input  logic                  running,
  input  logic [DATA_WIDTH-1:0] counter,
  output logic                  pwm
);

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] active;
  logic                  pending;
  logic                  capture;

  assign duty_ready = ~pending;
  assign capture    = duty_valid & ~pending;

  // A capture coinciding with a wrap keeps pending set, so it lands on the following wrap.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (capture) shadow <= duty;
      if (arm) active <= shadow;
      else if (wrap && pending) active <= shadow;
      if (capture) pending <= 1'b1;
      else if (arm || wrap) pending <= 1'b0;
      pwm <= running && (counter < active);
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// rtl/pwm_duty_scheduler.sv - shared prescaler, period counter and run FSM driving NUM_CH PWM channels
module pwm_duty_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int NUM_CH     = PWM_NUM_CH,
  parameter int DATA_WIDTH = PWM_DATA_WIDTH
) (
  input  logic                          up_clk,
  input  logic                          up_rstn,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         period,
  input  logic [PWM_PRESCALE_WIDTH-1:0] prescale,
  input  logic [DATA_WIDTH-1:0]         duty_0,
  input  logic [DATA_WIDTH-1:0]         duty_1,
  input  logic [DATA_WIDTH-1:0]         duty_2,
  input  logic [DATA_WIDTH-1:0]         duty_3,
  input  logic [NUM_CH-1:0]             duty_valid,
  output logic [NUM_CH-1:0]             duty_ready,
  output logic [NUM_CH-1:0]             pwm,
  output logic                          period_sync,
  output logic                          busy
);

  sched_state_t                  state;
  sched_state_t                  next_state;
  logic [DATA_WIDTH-1:0]         counter;
  logic [DATA_WIDTH-1:0]         period_act;
  logic [PWM_PRESCALE_WIDTH-1:0] prescaler;
  logic [PWM_PRESCALE_WIDTH-1:0] prescale_act;
  logic                          running;
  logic                          arm;
  logic                          tick;
  logic                          wrap;
  logic [DATA_WIDTH-1:0]         duty_arr [NUM_CH];

  assign running = (state == ST_RUN) || (state == ST_STOP);
  assign arm     = (state == ST_ARM);
  assign tick    = running && (prescaler == prescale_act);
  assign wrap    = tick && (counter == period_act);

  assign duty_arr[0] = duty_0;
  assign duty_arr[1] = duty_1;
  assign duty_arr[2] = duty_2;
  assign duty_arr[3] = duty_3;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (enable) next_state = ST_ARM;
      ST_ARM:  next_state = ST_RUN;
      ST_RUN:  if (!enable) next_state = ST_STOP;
      ST_STOP: begin
        if (enable) next_state = ST_RUN;
        else if (wrap) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Prescale is latched alongside period so mid-period input changes cannot stretch a period.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state        <= ST_IDLE;
      counter      <= '0;
      prescaler    <= '0;
      period_act   <= '0;
      prescale_act <= '0;
      period_sync  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state       <= next_state;
      period_sync <= wrap;
      busy        <= (next_state != ST_IDLE);
      if (arm) begin
        counter      <= '0;
        prescaler    <= '0;
        period_act   <= period;
        prescale_act <= prescale;
      end else if (running) begin
        prescaler <= tick ? '0 : prescaler + PWM_PRESCALE_WIDTH'(1);
        if (wrap) begin
          counter      <= '0;
          period_act   <= period;
          prescale_act <= prescale;
        end else if (tick) begin
          counter <= counter + DATA_WIDTH'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_sched_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .up_clk    (up_clk),
      .up_rstn   (up_rstn),
      .duty      (duty_arr[i]),
      .duty_valid(duty_valid[i]),
      .duty_ready(duty_ready[i]),
      .arm       (arm),
      .wrap      (wrap),
      .running   (running),
      .counter   (counter),
      .pwm       (pwm[i])
    );
  end

endmodule

// File: doc/pwm_duty_scheduler.md
PWM_DUTY_SCHEDULER -- requirements
Module: pwm_duty_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels; SHALL be fixed at 4 in this revision.
REQ-002 Parameter DATA_WIDTH, default 12, width of duty, period and counter values.
REQ-003 up_clk  input  1  clock; all logic SHALL be synchronous to its rising edge.
REQ-004 up_rstn  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 period  input  12  period length minus one, in prescaled ticks; sampled only at ARM and at wrap.
REQ-007 prescale  input  8  tick divider; a tick SHALL occur every prescale+1 cycles.
REQ-008 duty_0 .. duty_3  input  12 each  requested high-time in ticks, per channel.
REQ-009 duty_valid  input  4  per-channel duty update request.
REQ-010 duty_ready  output  4  per-channel update accept; equals ~pending[i].
REQ-011 pwm  output  4  PWM outputs, registered.
REQ-012 period_sync  output  1  one-cycle pulse on every counter wrap.
REQ-013 busy  output  1  high in ARM, RUN and STOP.

Function
REQ-014 FSM states IDLE, ARM, RUN, STOP; reset state IDLE.
REQ-015 IDLE->ARM when enable=1; ARM->RUN unconditionally after one cycle.
REQ-016 RUN->STOP when enable=0; STOP->RUN when enable returns to 1 before wrap; STOP->IDLE on wrap.
REQ-017 ARM: counter<=0, prescaler<=0, period_act<=period, active duty[i]<=shadow[i] for all i, pending<=0.
REQ-018 Prescaler counts 0..prescale in RUN/STOP; tick asserted when prescaler==prescale, then prescaler returns to 0.
REQ-019 On tick: counter==period_act -> counter<=0 (wrap), else counter<=counter+1.
REQ-020 On wrap: period_sync=1 next cycle; period_act<=period; active[i]<=shadow[i] only where pending[i]=1; pending[i]<=0.
REQ-021 Handshake: duty_valid[i]&duty_ready[i] in any state SHALL load shadow[i]<=duty_i and set pending[i].
REQ-022 Capture and wrap in the same cycle: wrap uses pre-capture pending; the new value SHALL apply at the following wrap.
REQ-023 pwm[i] SHALL be registered (counter<active[i]) in RUN/STOP, 0 in IDLE/ARM; latency one cycle from counter.
REQ-024 duty 0 -> pwm constantly low; duty > period_act -> pwm constantly high; no comparison wraps.
REQ-025 period=0: counter stays 0, wrap on every tick.
REQ-026 Mid-period changes of period, prescale or duty inputs SHALL NOT affect the current period (glitch-free).
REQ-027 busy SHALL be registered from FSM state (high when state!=IDLE).

Reset
REQ-028 On up_rstn=0: state IDLE; counter, prescaler, period_act, shadow, active, pending = 0.
REQ-029 Outputs in reset: pwm=0, period_sync=0, busy=0, duty_ready=4'b1111.
REQ-030 Reset asserted mid-period SHALL drive pwm low asynchronously; no pending update survives reset.

Structure
REQ-031 Package pwm_sched_pkg SHALL hold FSM state encoding, DATA_WIDTH and NUM_CH constants.
REQ-032 Sub-module pwm_sched_channel SHALL hold shadow/active/pending/compare for one channel, instantiated NUM_CH times.
REQ-033 The counter, prescaler and FSM SHALL be shared, single instance in the top.

Verification
REQ-034 prescale=0, period=9, duty_0=3, enable=1 -> pwm[0] high 3 of every 10 cycles, period_sync every 10 cycles.
REQ-035 In RUN, duty_1 from 2 to 7 mid-period -> duty_ready[1] low until wrap; new width visible from next period, no glitch.
REQ-036 duty_2=0, duty_3=15 with period=9 -> pwm[2] always 0, pwm[3] always 1 in RUN.
REQ-037 Deassert enable at counter=4, period=9 -> period completes, period_sync pulses, FSM IDLE, pwm=0, busy=0.
REQ-038 prescale=3, period=1, duty_0=1 -> pwm[0] high 4 cycles, low 4 cycles.
REQ-039 Assert up_rstn=0 mid-period with pending update -> pwm=0 immediately, duty_ready=4'b1111 after release.
